// File: rtl/data_mem_interface.sv
// RV32I MEM-stage data-cache interface: alignment check, byte lanes,
// load extraction and a three-state IDLE/ACCESS/RESP handshake.
module data_mem_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  ldr_op,
    input  logic [2:0]  str_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dcache_read,
    output logic        dcache_write,
    output logic [31:0] dcache_address,
    output logic [31:0] dcache_wdata,
    output logic [3:0]  dcache_mbe,
    input  logic [31:0] dcache_rdata,
    input  logic        dcache_resp,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        misaligned
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic [31:0] r_load_data;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_is_read;

    logic        w_req;
    logic        w_aligned;
    logic [1:0]  w_size;
    logic        w_uns;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;

    assign w_req     = mem_read | mem_write;
    assign load_data = r_load_data;

    // Size: 0 byte, 1 half, 2 word; a read wins when both requests are high
    always_comb begin
        w_size = 2'd2;
        w_uns  = 1'b0;
        if (mem_read) begin
            unique case (ldr_op)
                3'b000:  w_size = 2'd0;
                3'b001:  w_size = 2'd1;
                3'b100:  begin w_size = 2'd0; w_uns = 1'b1; end
                3'b101:  begin w_size = 2'd1; w_uns = 1'b1; end
                default: w_size = 2'd2;
            endcase
        end else begin
            unique case (str_op)
                3'b000:  w_size = 2'd0;
                3'b001:  w_size = 2'd1;
                default: w_size = 2'd2;
            endcase
        end
        unique case (w_size)
            2'd0:    w_aligned = 1'b1;
            2'd1:    w_aligned = ~addr[0];
            default: w_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        unique case (r_addr[1:0])
            2'd0:    w_byte = dcache_rdata[7:0];
            2'd1:    w_byte = dcache_rdata[15:8];
            2'd2:    w_byte = dcache_rdata[23:16];
            default: w_byte = dcache_rdata[31:24];
        endcase
        w_half = r_addr[1] ? dcache_rdata[31:16] : dcache_rdata[15:0];
        unique case (r_size)
            2'd0:    w_ext = r_uns ? {24'h0, w_byte}
                                   : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_ext = r_uns ? {16'h0, w_half}
                                   : {{16{w_half[15]}}, w_half};
            default: w_ext = dcache_rdata;
        endcase
    end

    always_comb begin
        w_mbe   = 4'hF;
        w_wdata = 32'h0;
        if (!r_is_read) begin
            unique case (r_size)
                2'd0: begin
                    w_mbe   = 4'b0001 << r_addr[1:0];
                    w_wdata = {4{r_sdata[7:0]}};
                end
                2'd1: begin
                    w_mbe   = 4'b0011 << r_addr[1:0];
                    w_wdata = {2{r_sdata[15:0]}};
                end
                default: begin
                    w_mbe   = 4'hF;
                    w_wdata = r_sdata;
                end
            endcase
        end
    end

    // Outputs are gated by rst so a request held during reset stays invisible
    always_comb begin
        w_next         = r_state;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = 32'h0;
        dcache_wdata   = 32'h0;
        dcache_mbe     = 4'h0;
        stall          = 1'b0;
        done           = 1'b0;
        misaligned     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!rst && w_req) begin
                    if (w_aligned) begin
                        stall  = 1'b1;
                        w_next = ACCESS;
                    end else begin
                        misaligned = 1'b1;
                    end
                end
            end
            ACCESS: begin
                dcache_read    = r_is_read;
                dcache_write   = ~r_is_read;
                dcache_address = {r_addr[31:2], 2'b00};
                dcache_wdata   = w_wdata;
                dcache_mbe     = w_mbe;
                stall          = 1'b1;
                if (dcache_resp) w_next = RESP;
            end
            RESP: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= 32'h0;
            r_sdata     <= 32'h0;
            r_load_data <= 32'h0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_is_read   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == ACCESS) begin
                r_addr    <= addr;
                r_sdata   <= store_data;
                r_size    <= w_size;
                r_uns     <= w_uns;
                r_is_read <= mem_read;
            end
            if (r_state == ACCESS && dcache_resp && r_is_read) begin
                r_load_data <= w_ext;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_interface.sv
// Scoreboard bench for data_mem_interface: a cache responder and a
// completion monitor pop expectations queued by the directed stimulus.
module tb_data_mem_interface;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  ldr_op, str_op;
    logic [31:0] addr, store_data;
    logic        dcache_read, dcache_write;
    logic [31:0] dcache_address, dcache_wdata;
    logic [3:0]  dcache_mbe;
    logic [31:0] dcache_rdata;
    logic        dcache_resp;
    logic [31:0] load_data;
    logic        stall, done, misaligned;

    typedef struct {
        bit          mis;
        logic [31:0] ld;
    } rsp_t;

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [3:0]  mbe;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          dly;
    } acc_t;

    rsp_t        rsp_q[$];
    acc_t        acc_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_ld = 32'h0;

    data_mem_interface dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .ldr_op(ldr_op), .str_op(str_op),
        .addr(addr), .store_data(store_data),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_mbe(dcache_mbe), .dcache_rdata(dcache_rdata),
        .dcache_resp(dcache_resp), .load_data(load_data),
        .stall(stall), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Completion monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done || misaligned) begin
                rsp_t e;
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: done=%b mis=%b expected none",
                             done, misaligned);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_mis", 32'(misaligned), 32'(e.mis));
                    chk("rsp_done", 32'(done), 32'(!e.mis));
                    chk("rsp_stall", 32'(stall), 32'h0);
                    chk("load_data", load_data, e.ld);
                    if (e.mis)
                        chk("mis_strobe", 32'({dcache_read, dcache_write}), 32'h0);
                end
            end
        end
    end

    // Cache responder: checks request fields every cycle they are held
    initial begin
        acc_t c;
        int   cnt;
        bit   busy, chk_on;
        busy = 0; chk_on = 0; cnt = 0;
        c = '{0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        dcache_resp  = 1'b0;
        dcache_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dcache_resp = 1'b0;
            if (!busy && (dcache_read || dcache_write)) begin
                busy = 1;
                if (acc_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_access: rd=%b wr=%b expected none",
                             dcache_read, dcache_write);
                    chk_on = 0;
                    cnt    = 0;
                end else begin
                    c      = acc_q.pop_front();
                    chk_on = 1;
                    cnt    = c.dly;
                end
            end else if (busy && !(dcache_read || dcache_write)) begin
                busy = 0;
            end
            if (busy) begin
                if (chk_on) begin
                    chk("acc_write", 32'(dcache_write), 32'(c.wr));
                    chk("acc_read", 32'(dcache_read), 32'(!c.wr));
                    chk("acc_addr", dcache_address, c.a);
                    chk("acc_mbe", 32'(dcache_mbe), 32'(c.mbe));
                    chk("acc_wdata", dcache_wdata, c.wd);
                    chk("acc_stall", 32'(stall), 32'h1);
                end
                if (cnt == 0) begin
                    dcache_resp  = 1'b1;
                    dcache_rdata = c.rdata;
                    busy = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic do_req(bit rd, bit wr, logic [2:0] lop, logic [2:0] sop,
                          logic [31:0] a, logic [31:0] sd);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr;
        ldr_op = lop; str_op = sop;
        addr = a; store_data = sd;
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_done(string nm);
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: done=%b expected 1", nm, done);
        end
    endtask

    task automatic load(logic [2:0] op, logic [31:0] a, logic [31:0] wa,
                        logic [31:0] rdata, int dly, logic [31:0] exp_ld,
                        bit both);
        acc_q.push_back('{0, wa, 4'hF, 32'h0, rdata, dly});
        cur_ld = exp_ld;
        rsp_q.push_back('{0, exp_ld});
        do_req(1, both, op, 3'b010, a, 32'h5A5A_5A5A);
        wait_done("load");
    endtask

    task automatic store(logic [2:0] op, logic [31:0] a, logic [31:0] wa,
                         logic [31:0] sd, logic [3:0] mbe,
                         logic [31:0] wd, int dly);
        acc_q.push_back('{1, wa, mbe, wd, 32'hFFFF_FFFF, dly});
        rsp_q.push_back('{0, cur_ld});
        do_req(0, 1, 3'b000, op, a, sd);
        wait_done("store");
    endtask

    task automatic misreq(bit rd, logic [2:0] op, logic [31:0] a);
        rsp_q.push_back('{1, cur_ld});
        do_req(rd, !rd, op, op, a, 32'h1234_5678);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_read = 0; mem_write = 0;
        ldr_op = 0; str_op = 0; addr = 0; store_data = 0;
        repeat (2) @(negedge clk);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_strobes", 32'({dcache_read, dcache_write}), 32'h0);
        chk("rst_pulses", 32'({stall, done, misaligned}), 32'h0);
        chk("rst_mbe", 32'(dcache_mbe), 32'h0);
        rst = 1'b0;

        load(3'b000, 32'h1003, 32'h1000, 32'h80FF_1234, 0, 32'hFFFF_FF80, 0);
        store(3'b001, 32'h2002, 32'h2000, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 2);
        misreq(1, 3'b010, 32'h3001);
        load(3'b101, 32'h4002, 32'h4000, 32'h8765_4321, 5, 32'h0000_8765, 0);
        load(3'b100, 32'h5000, 32'h5000, 32'h1234_56AB, 0, 32'h0000_00AB, 1);
        load(3'b001, 32'h4002, 32'h4000, 32'h8765_4321, 1, 32'hFFFF_8765, 0);
        load(3'b000, 32'h9000, 32'h9000, 32'h0000_007F, 0, 32'h0000_007F, 0);
        load(3'b100, 32'h9001, 32'h9000, 32'h0000_8000, 0, 32'h0000_0080, 0);
        load(3'b001, 32'h9002, 32'h9000, 32'h7FFF_0000, 0, 32'h0000_7FFF, 0);
        load(3'b011, 32'h8000, 32'h8000, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0);
        misreq(1, 3'b110, 32'h8002);
        load(3'b111, 32'h8004, 32'h8004, 32'h0BAD_BEEF, 3, 32'h0BAD_BEEF, 0);
        misreq(1, 3'b001, 32'h8001);
        misreq(1, 3'b101, 32'h8003);
        misreq(0, 3'b010, 32'h8002);
        misreq(0, 3'b001, 32'h8001);
        misreq(0, 3'b111, 32'h8001);
        store(3'b000, 32'h7001, 32'h7000, 32'h1122_3344, 4'b0010, 32'h4444_4444, 0);
        store(3'b000, 32'h7003, 32'h7000, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5, 1);
        store(3'b001, 32'h2000, 32'h2000, 32'h1234_5678, 4'b0011, 32'h5678_5678, 0);
        store(3'b010, 32'h7004, 32'h7004, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 0);
        store(3'b011, 32'h700C, 32'h700C, 32'h0102_0304, 4'hF, 32'h0102_0304, 0);

        // Reset in the middle of a long access
        acc_q.push_back('{0, 32'h6000, 4'hF, 32'h0, 32'h0, 20});
        do_req(1, 0, 3'b010, 3'b000, 32'h6000, 32'h0);
        @(negedge clk);
        chk("pre_rst_stall", 32'(stall), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_strobes", 32'({dcache_read, dcache_write}), 32'h0);
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_load_data", load_data, 32'h0);
        cur_ld = 32'h0;
        mem_read = 1'b1; ldr_op = 3'b010; addr = 32'h6004;
        @(posedge clk); #1;
        chk("rst_gates_stall", 32'(stall), 32'h0);
        chk("rst_no_done", 32'(done), 32'h0);
        acc_q.push_back('{0, 32'h6004, 4'hF, 32'h0, 32'h1234_5678, 0});
        rsp_q.push_back('{0, 32'h1234_5678});
        cur_ld = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_accept_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        mem_read = 1'b0;
        wait_done("post_rst");

        repeat (5) @(negedge clk);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
        chk("acc_q_empty", 32'(acc_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/data_mem_interface.md
DATA_MEM_INTERFACE -- requirements
Module: data_mem_interface

Interface
REQ-001 SHALL have no parameters; all widths are fixed at RV32I values.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-003 Ports (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 rst  in  1  async active-high reset
 mem_read  in  1  MEM-stage load request from control word
 mem_write  in  1  MEM-stage store request from control word
 ldr_op  in  3  load funct3 (lb=000 lh=001 lw=010 lbu=100 lhu=101)
 str_op  in  3  store funct3 (sb=000 sh=001 sw=010)
 addr  in  32  effective address from ALU
 store_data  in  32  rs2 value
 dcache_read  out  1  d-cache read strobe
 dcache_write  out  1  d-cache write strobe
 dcache_address  out  32  word-aligned address {addr[31:2],2'b00}
 dcache_wdata  out  32  lane-aligned store data
 dcache_mbe  out  4  byte enables
 dcache_rdata  in  32  d-cache read word
 dcache_resp  in  1  d-cache completion, one-cycle pulse
 load_data  out  32  extended load result, registered
 stall  out  1  hold pipeline
 done  out  1  one-cycle completion pulse
 misaligned  out  1  one-cycle misaligned-access pulse

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-005 In IDLE with a request (mem_read|mem_write) and aligned address: latch addr, op, store_data, direction; next state ACCESS; stall=1 combinationally in that same cycle.
REQ-006 mem_read and mem_write both high SHALL be treated as a read; write ignored.
REQ-007 Alignment: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0; byte ops always aligned.
REQ-008 Misaligned request in IDLE: no cache strobe, misaligned=1 for that cycle, stall=0, load_data unchanged, stay IDLE.
REQ-009 Undefined ldr_op (011,110,111) SHALL behave as lw; undefined str_op SHALL behave as sw.
REQ-010 In ACCESS: exactly one of dcache_read/dcache_write =1; dcache_address, dcache_wdata, dcache_mbe driven from latched values and held stable until dcache_resp; stall=1.
REQ-011 dcache_resp in ACCESS: for reads, load_data <= extracted value at that edge; next state RESP; strobes drop in RESP.
REQ-012 In RESP: done=1, stall=0, inputs ignored; next state IDLE unconditionally.
REQ-013 Minimum latency: request cycle -> ACCESS (>=1 cycle) -> RESP; done asserts 2 cycles after request acceptance with zero-wait cache.
REQ-014 dcache_mbe: read 1111; sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111.
REQ-015 dcache_wdata: sb byte replicated ×4; sh halfword replicated ×2; sw store_data unchanged.
REQ-016 Load extraction: lb sign-extend byte addr[1:0]; lbu zero-extend same; lh sign-extend half addr[1]; lhu zero-extend; lw full word.
REQ-017 dcache_resp outside ACCESS SHALL be ignored.
REQ-018 Outside ACCESS: dcache_read=dcache_write=0, mbe=0000, address/wdata=0.

Reset
REQ-019 rst SHALL force IDLE, load_data=0, all strobes/pulses/stall=0 immediately (async), including mid-ACCESS; pending access abandoned, no done pulse.
REQ-020 First request after rst deassert SHALL be accepted on the first rising edge without extra delay.

Verification
REQ-021 lb addr=0x1003, rdata=0x80FF_1234, resp 1 cycle after strobe -> mbe=1111, address=0x1000, load_data=0xFFFF_FF80, done 1 cycle.
REQ-022 sh addr=0x2002, store_data=0x0000_ABCD -> dcache_write=1, mbe=1100, wdata=0xABCD_ABCD, stall high until resp, done pulse.
REQ-023 lw addr=0x3001 -> misaligned=1 one cycle, no strobe, stall=0, load_data unchanged.
REQ-024 lhu addr=0x4002, resp delayed 5 cycles, rdata=0x8765_4321 -> strobe/address stable 5 cycles, load_data=0x0000_8765.
REQ-025 rst asserted mid-ACCESS -> strobes and stall drop same cycle, no done, next lw accepted normally.
REQ-026 mem_read=mem_write=1, lbu addr=0x5000 -> read issued, no write, load_data=zero-extended byte 0.
